imem_loader: RTL and testbench

Boot-time program loader that sits in front of the instruction memory write port, opposite the processor's read-only fetch path. It accepts a byte stream (length header, then big-endian instruction words), assembles 32-bit words and writes them to consecutive word addresses. It holds the processor in reset until the load completes, then releases it so fetch starts at PC 0.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_assembler.sv | 34 +++
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects big-endian bytes into a 32-bit word; word_ready pulses the cycle
// after the 4th byte of a word is accepted.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [1:0]  cnt,
  output logic [31:0] word,
  output logic        word_ready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= en && (cnt == 2'(WORD_BYTES - 1));
      if (en) begin
        word <= {word[23:0], din};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory and
// holds the processor in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   words_loaded
);

  state_t      state, state_nxt;
  logic [15:0] n_words;
  logic [15:0] hdr_n;
  logic [1:0]  byte_cnt;
  logic        accept;
  logic        start_load;
  logic        hdr_last;

  assign accept     = s_valid && s_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign hdr_last   = (state == HDR) && accept && (byte_cnt == 2'(HDR_BYTES - 1));
  // Header count is judged from the high byte already shifted in plus the
  // byte being accepted, so the post-header state is visible one cycle later.
  assign hdr_n      = {wr_data[7:0], s_data};

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_load || hdr_last),
    .en         (accept),
    .din        (s_data),
    .cnt        (byte_cnt),
    .word       (wr_data),
    .word_ready (wr_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst   = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = HDR;
      end
      HDR: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (hdr_last) begin
          if (hdr_n == 16'd0)            state_nxt = DONE;
          else if (32'(hdr_n) > DEPTH)   state_nxt = ERR;
          else                           state_nxt = LOAD;
        end
      end
      LOAD: begin
        s_ready = !wr_en;
        busy    = 1'b1;
        if (wr_en && (words_loaded + 16'd1 == n_words)) state_nxt = DONE;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_nxt = HDR;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = HDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr      <= '0;
      words_loaded <= '0;
      n_words      <= '0;
    end else begin
      if (start_load) begin
        wr_addr      <= '0;
        words_loaded <= '0;
      end else if (wr_en) begin
        wr_addr      <= wr_addr + AW'(1);
        words_loaded <= words_loaded + 16'd1;
      end
      if (hdr_last) n_words <= hdr_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      checks++;
      assert (s_ready === 1'b0) else begin
        errors++;
        $error("FAIL s_ready_on_wr: observed %b expected 0", s_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chkb("rst_cpu_rst", cpu_rst, 1'b1);
    chkb("rst_s_ready", s_ready, 1'b0);
    chkb("rst_wr_en",   wr_en,   1'b0);
    chk ("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk ("rst_wr_data", wr_data, 32'h0);
    chkb("rst_busy",    busy,    1'b0);
    chkb("rst_done",    done,    1'b0);
    chkb("rst_err",     err,     1'b0);
    chk ("rst_words",   32'(words_loaded), 32'h0);
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge following the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    logic acc;
    logic ok;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      acc = s_ready;
      @(negedge clk);
      ok = acc;
    end
    s_valid = 1'b0;
    chkb("byte_accept", ok, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gapmax);
    exp_q.push_back(w);
    for (int unsigned i = 0; i < 4; i++)
      send_byte(w[31 - 8*i -: 8], (gapmax == 0) ? 0 : $urandom_range(gapmax, 0));
  endtask

  task automatic check_log();
    chk("log_count", 32'(log_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_data.size() && i < exp_q.size(); i++) begin
      chk("log_addr", 32'(log_addr[i]), 32'(i));
      chk("log_data", log_data[i], exp_q[i]);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'hA5000000 ^ (i * 32'h01030507);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    chkb("idle_cpu_rst", cpu_rst, 1'b1);

    // Two-word load
    clear_logs();
    pulse_start();
    chkb("hdr_busy", busy, 1'b1);
    chkb("hdr_s_ready", s_ready, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    chkb("load_busy", busy, 1'b1);
    send_word(32'h8C010004, 0);
    chkb("w0_en", wr_en, 1'b1);
    chk ("w0_addr", 32'(wr_addr), 32'd0);
    chk ("w0_data", wr_data, 32'h8C010004);
    send_word(32'h00221820, 0);
    chkb("w1_en", wr_en, 1'b1);
    chk ("w1_addr", 32'(wr_addr), 32'd1);
    chk ("w1_data", wr_data, 32'h00221820);
    chkb("w1_cpu_rst", cpu_rst, 1'b1);
    @(negedge clk);
    chkb("t1_done", done, 1'b1);
    chkb("t1_cpu_rst", cpu_rst, 1'b0);
    chk ("t1_words", 32'(words_loaded), 32'd2);
    chkb("t1_busy", busy, 1'b0);
    s_valid = 1'b1; s_data = 8'hFF;
    repeat (3) @(negedge clk);
    chkb("done_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    check_log();

    // Zero-length header
    clear_logs();
    pulse_start();
    chkb("restart_cpu_rst", cpu_rst, 1'b1);
    chkb("restart_done_clr", done, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chkb("zero_done", done, 1'b1);
    chkb("zero_cpu_rst", cpu_rst, 1'b0);
    chk ("zero_words", 32'(words_loaded), 32'd0);
    check_log();

    // Oversize header (257 words)
    clear_logs();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chkb("big_err", err, 1'b1);
    chkb("big_cpu_rst", cpu_rst, 1'b1);
    chkb("big_done", done, 1'b0);
    chkb("big_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chkb("err_s_ready", s_ready, 1'b0);
    check_log();

    // Restart from ERR with a gap-free 16-word load
    pulse_start();
    chkb("err_restart_err", err, 1'b0);
    chkb("err_restart_busy", busy, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    for (int unsigned i = 0; i < 16; i++) send_word(pat(i), 0);
    @(negedge clk);
    chkb("w16_done", done, 1'b1);
    chk ("w16_words", 32'(words_loaded), 32'd16);
    check_log();

    // Same 16 words with random stream gaps
    clear_logs();
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h10, 2);
    for (int unsigned i = 0; i < 16; i++) send_word(pat(i), 2);
    @(negedge clk);
    chkb("gap_done", done, 1'b1);
    chk ("gap_words", 32'(words_loaded), 32'd16);
    check_log();

    // Reset in the middle of the third word
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_word(32'h11112222, 0);
    send_word(32'h33334444, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_log();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_data", wr_data, 32'hDEADBEEF);
    @(negedge clk);
    chkb("post_rst_done", done, 1'b1);
    chk ("post_rst_words", 32'(words_loaded), 32'd1);
    check_log();

    // start while busy is ignored; start in DONE reloads from addr 0
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    pulse_start();
    chkb("ign_hdr_busy", busy, 1'b1);
    send_byte(8'h02, 0);
    w = 32'hCAFEF00D;
    exp_q.push_back(w);
    send_byte(w[31:24], 0);
    send_byte(w[23:16], 0);
    pulse_start();
    chkb("ign_load_busy", busy, 1'b1);
    send_byte(w[15:8], 0);
    send_byte(w[7:0], 0);
    send_word(32'h0BADC0DE, 0);
    @(negedge clk);
    chkb("ign_done", done, 1'b1);
    chk ("ign_words", 32'(words_loaded), 32'd2);
    check_log();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
